// File: rtl/riscv_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : riscv_muldiv_unit
// Description : Multi-cycle RISC-V M-extension execute unit. It sits beside
//               the single-cycle integer ALU and handles OP / funct7=0000001.
//               Multiplies complete in 2 cycles. Divide and remainder use an
//               iterative restoring divider that retires one quotient bit per
//               cycle, so they take WIDTH+1 cycles. Divide by zero, signed
//               overflow and illegal funct7 each complete in 1 cycle.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               kill                - pipeline flush, aborts any operation
//               in_valid/in_ready   - request handshake
//               op1, op2            - rs1 / rs2 operand values
//               funct3, funct7      - M-op select / must be 0000001
//               out_valid/out_ready - result handshake
//               result              - registered operation result
//               div_zero, illegal   - result flags, qualified by out_valid
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             kill,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             div_zero,
    output logic             illegal
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [6:0]       c_FUNCT7_M = 7'b0000001;
    localparam logic [WIDTH-1:0] c_MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] c_ALL_ONES = {WIDTH{1'b1}};

    state_t             r_state;
    logic [WIDTH-1:0]   r_op1;
    logic [WIDTH-1:0]   r_op2;
    logic [1:0]         r_mul_sel;    // funct3[1:0] of the latched multiply
    logic [WIDTH-1:0]   r_quo;        // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0]   r_rem;        // partial remainder
    logic [WIDTH-1:0]   r_divisor;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_q_neg;
    logic               r_r_neg;
    logic               r_is_rem;
    logic [WIDTH-1:0]   r_result;
    logic               r_out_valid;
    logic               r_div_zero;
    logic               r_illegal;

    // ------------------------------------------------------------------
    // Request decode (used only on the accept edge)
    // ------------------------------------------------------------------
    logic               w_accept;
    logic               w_signed_div;
    logic               w_op1_neg;
    logic               w_op2_neg;
    logic [WIDTH-1:0]   w_op1_mag;
    logic [WIDTH-1:0]   w_op2_mag;
    logic               w_overflow;

    assign in_ready     = (r_state == IDLE) && !kill;
    assign w_accept     = in_valid && in_ready;

    // DIV (100) and REM (110) are signed; DIVU and REMU have funct3[0] set.
    assign w_signed_div = !funct3[0];
    assign w_op1_neg    = w_signed_div && op1[WIDTH-1];
    assign w_op2_neg    = w_signed_div && op2[WIDTH-1];
    assign w_op1_mag    = w_op1_neg ? (~op1 + 1'b1) : op1;
    assign w_op2_mag    = w_op2_neg ? (~op2 + 1'b1) : op2;
    assign w_overflow   = w_signed_div && (op1 == c_MIN_NEG) && (op2 == c_ALL_ONES);

    // ------------------------------------------------------------------
    // Multiplier: sign-extend both operands to 2*WIDTH bits; the low
    // 2*WIDTH bits of the unsigned product are then the exact product
    // for every signedness combination.
    // ------------------------------------------------------------------
    logic               w_mul_a_sign;
    logic               w_mul_b_sign;
    logic [2*WIDTH-1:0] w_mul_a;
    logic [2*WIDTH-1:0] w_mul_b;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_mul_res;

    // MULH (01) and MULHSU (10) treat op1 as signed; only MULH signs op2.
    assign w_mul_a_sign = ((r_mul_sel == 2'b01) || (r_mul_sel == 2'b10)) && r_op1[WIDTH-1];
    assign w_mul_b_sign = (r_mul_sel == 2'b01) && r_op2[WIDTH-1];
    assign w_mul_a      = {{WIDTH{w_mul_a_sign}}, r_op1};
    assign w_mul_b      = {{WIDTH{w_mul_b_sign}}, r_op2};
    assign w_prod       = w_mul_a * w_mul_b;
    assign w_mul_res    = (r_mul_sel == 2'b00) ? w_prod[WIDTH-1:0] : w_prod[2*WIDTH-1:WIDTH];

    // ------------------------------------------------------------------
    // Restoring divider step. The trial value is below 2*divisor, so the
    // (WIDTH+1)-bit difference has a valid sign bit.
    // ------------------------------------------------------------------
    logic [WIDTH:0]     w_trial;
    logic [WIDTH:0]     w_diff;
    logic               w_fits;
    logic [WIDTH-1:0]   w_rem_next;
    logic [WIDTH-1:0]   w_quo_next;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    assign w_trial    = {r_rem, r_quo[WIDTH-1]};
    assign w_diff     = w_trial - {1'b0, r_divisor};
    assign w_fits     = !w_diff[WIDTH];
    assign w_rem_next = w_fits ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];
    assign w_quo_next = {r_quo[WIDTH-2:0], w_fits};
    assign w_quo_fix  = r_q_neg ? (~w_quo_next + 1'b1) : w_quo_next;
    assign w_rem_fix  = r_r_neg ? (~w_rem_next + 1'b1) : w_rem_next;

    // ------------------------------------------------------------------
    // Control FSM and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_op1       <= '0;
            r_op2       <= '0;
            r_mul_sel   <= '0;
            r_quo       <= '0;
            r_rem       <= '0;
            r_divisor   <= '0;
            r_cnt       <= '0;
            r_q_neg     <= 1'b0;
            r_r_neg     <= 1'b0;
            r_is_rem    <= 1'b0;
            r_result    <= '0;
            r_out_valid <= 1'b0;
            r_div_zero  <= 1'b0;
            r_illegal   <= 1'b0;
        end else if (kill) begin
            // Flush wins over accept and handoff: the result is dropped.
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_div_zero  <= 1'b0;
            r_illegal   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_op1     <= op1;
                        r_op2     <= op2;
                        r_mul_sel <= funct3[1:0];
                        if (funct7 != c_FUNCT7_M) begin
                            r_state     <= DONE;
                            r_result    <= '0;
                            r_illegal   <= 1'b1;
                            r_out_valid <= 1'b1;
                        end else if (!funct3[2]) begin
                            r_state <= MUL;
                        end else if (op2 == '0) begin
                            // DIV/DIVU give all ones, REM/REMU give the dividend.
                            r_state     <= DONE;
                            r_result    <= funct3[1] ? op1 : c_ALL_ONES;
                            r_div_zero  <= 1'b1;
                            r_out_valid <= 1'b1;
                        end else if (w_overflow) begin
                            r_state     <= DONE;
                            r_result    <= funct3[1] ? '0 : c_MIN_NEG;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_state   <= DIV;
                            r_quo     <= w_op1_mag;
                            r_rem     <= '0;
                            r_divisor <= w_op2_mag;
                            r_cnt     <= CNT_W'(WIDTH);
                            r_q_neg   <= w_op1_neg ^ w_op2_neg;
                            r_r_neg   <= w_op1_neg;
                            r_is_rem  <= funct3[1];
                        end
                    end
                end

                MUL: begin
                    r_state     <= DONE;
                    r_result    <= w_mul_res;
                    r_out_valid <= 1'b1;
                end

                DIV: begin
                    r_quo <= w_quo_next;
                    r_rem <= w_rem_next;
                    r_cnt <= r_cnt - CNT_W'(1);
                    // Last iteration: apply the sign fix to this step's outputs.
                    if (r_cnt == CNT_W'(1)) begin
                        r_state     <= DONE;
                        r_result    <= r_is_rem ? w_rem_fix : w_quo_fix;
                        r_out_valid <= 1'b1;
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_div_zero  <= 1'b0;
                        r_illegal   <= 1'b0;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign div_zero  = r_div_zero;
    assign illegal   = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_riscv_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_riscv_muldiv_unit
// Description : Directed self-checking bench for riscv_muldiv_unit. Expected
//               results are queued when a request is driven and compared when
//               the unit raises out_valid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_muldiv_unit;

    localparam int          c_WIDTH   = 32;
    localparam int          c_TIMEOUT = 200;
    localparam logic [6:0]  c_F7_M    = 7'b0000001;

    logic              clk;
    logic              rst;
    logic              kill;
    logic              in_valid;
    logic              in_ready;
    logic [c_WIDTH-1:0] op1;
    logic [c_WIDTH-1:0] op2;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic              out_valid;
    logic              out_ready;
    logic [c_WIDTH-1:0] result;
    logic              div_zero;
    logic              illegal;

    typedef struct {
        logic [c_WIDTH-1:0] res;
        logic               dz;
        logic               ill;
        int                 lat;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    riscv_muldiv_unit #(.WIDTH(c_WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .kill      (kill),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op1       (op1),
        .op2       (op2),
        .funct3    (funct3),
        .funct7    (funct7),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .div_zero  (div_zero),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one request for a single accept edge, then scramble the
    // operand inputs so the unit must rely on its latched copies.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b,
                            input logic [2:0] f3, input logic [6:0] f7);
        @(negedge clk);
        op1      = a;
        op2      = b;
        funct3   = f3;
        funct7   = f7;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op1      = $urandom;
        op2      = $urandom;
        funct3   = 3'($urandom);
        funct7   = 7'($urandom);
    endtask

    // Queue the expectation, issue the request, wait for out_valid and
    // compare. With handoff set, also check the return to idle.
    task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] exp_res, input logic exp_dz,
                         input logic exp_ill, input int exp_lat, input bit handoff);
        exp_t e;
        int   edges;
        sb.push_back('{exp_res, exp_dz, exp_ill, exp_lat});
        @(negedge clk);
        check({tag, "_in_ready_idle"}, 64'(in_ready), 64'd1);
        start_op(a, b, f3, f7);
        edges = 1;
        @(negedge clk);
        if (!out_valid && exp_lat > 1)
            check({tag, "_in_ready_busy"}, 64'(in_ready), 64'd0);
        while (!out_valid && edges < c_TIMEOUT) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        check({tag, "_out_valid"}, 64'(out_valid), 64'd1);
        e = sb.pop_front();
        check({tag, "_result"},   64'(result),   64'(e.res));
        check({tag, "_div_zero"}, 64'(div_zero), 64'(e.dz));
        check({tag, "_illegal"},  64'(illegal),  64'(e.ill));
        check({tag, "_latency"},  64'(edges),    64'(e.lat));
        if (handoff) begin
            @(posedge clk);
            @(negedge clk);
            check({tag, "_handoff_valid"}, 64'(out_valid), 64'd0);
            check({tag, "_handoff_flags"}, 64'({div_zero, illegal}), 64'd0);
            check({tag, "_handoff_ready"}, 64'(in_ready), 64'd1);
        end
    endtask

    initial begin
        bit seen;
        rst       = 1'b1;
        kill      = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        op1       = '0;
        op2       = '0;
        funct3    = '0;
        funct7    = c_F7_M;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result",    64'(result),    64'd0);
        check("rst_flags",     64'({div_zero, illegal}), 64'd0);
        rst = 1'b0;

        // Multiplies
        do_op("mul",    32'd7,        32'hFFFFFFFA, 3'b000, c_F7_M, 32'hFFFFFFD6, 1'b0, 1'b0, 2, 1'b1);
        do_op("mulh",   32'h80000000, 32'h80000000, 3'b001, c_F7_M, 32'h40000000, 1'b0, 1'b0, 2, 1'b1);
        do_op("mulhsu", 32'h80000000, 32'h80000000, 3'b010, c_F7_M, 32'hC0000000, 1'b0, 1'b0, 2, 1'b1);
        do_op("mulhu",  32'h80000000, 32'h80000000, 3'b011, c_F7_M, 32'h40000000, 1'b0, 1'b0, 2, 1'b1);
        do_op("mulhu2", 32'hFFFFFFFF, 32'hFFFFFFFF, 3'b011, c_F7_M, 32'hFFFFFFFE, 1'b0, 1'b0, 2, 1'b1);

        // Divides
        do_op("div",    32'hFFFFFFF9, 32'd2,        3'b100, c_F7_M, 32'hFFFFFFFD, 1'b0, 1'b0, 33, 1'b1);
        do_op("rem",    32'hFFFFFFF9, 32'd2,        3'b110, c_F7_M, 32'hFFFFFFFF, 1'b0, 1'b0, 33, 1'b1);
        do_op("divu",   32'd100,      32'd7,        3'b101, c_F7_M, 32'd14,       1'b0, 1'b0, 33, 1'b1);
        do_op("remu",   32'd100,      32'd7,        3'b111, c_F7_M, 32'd2,        1'b0, 1'b0, 33, 1'b1);
        do_op("div_neg_divisor", 32'd20, 32'hFFFFFFFD, 3'b100, c_F7_M, 32'hFFFFFFFA, 1'b0, 1'b0, 33, 1'b1);
        do_op("rem_neg_divisor", 32'd20, 32'hFFFFFFFD, 3'b110, c_F7_M, 32'd2,        1'b0, 1'b0, 33, 1'b1);

        // Corner cases
        do_op("divu_by0", 32'd5,        32'd0,        3'b101, c_F7_M, 32'hFFFFFFFF, 1'b1, 1'b0, 1, 1'b1);
        do_op("rem_by0",  32'd5,        32'd0,        3'b110, c_F7_M, 32'd5,        1'b1, 1'b0, 1, 1'b1);
        do_op("div_ovf",  32'h80000000, 32'hFFFFFFFF, 3'b100, c_F7_M, 32'h80000000, 1'b0, 1'b0, 1, 1'b1);
        do_op("rem_ovf",  32'h80000000, 32'hFFFFFFFF, 3'b110, c_F7_M, 32'd0,        1'b0, 1'b0, 1, 1'b1);
        do_op("illegal",  32'd9,        32'd3,        3'b000, 7'h20,  32'd0,        1'b0, 1'b1, 1, 1'b1);

        // Backpressure: result held for 10 cycles, then one-cycle handoff
        out_ready = 1'b0;
        do_op("bp", 32'd5, 32'd6, 3'b000, c_F7_M, 32'd30, 1'b0, 1'b0, 2, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("bp_hold_valid",  64'(out_valid), 64'd1);
            check("bp_hold_result", 64'(result),    64'd30);
            check("bp_hold_ready",  64'(in_ready),  64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_release_valid", 64'(out_valid), 64'd0);
        check("bp_release_ready", 64'(in_ready),  64'd1);

        // kill at divide iteration 10
        start_op(32'd1000, 32'd3, 3'b101, c_F7_M);
        repeat (9) @(posedge clk);
        @(negedge clk);
        kill = 1'b1;
        #1;
        check("kill_in_ready_comb", 64'(in_ready), 64'd0);
        @(posedge clk);
        @(negedge clk);
        kill = 1'b0;
        #1;
        check("kill_idle_ready", 64'(in_ready),  64'd1);
        check("kill_no_valid",   64'(out_valid), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            seen = seen | out_valid;
        end
        check("kill_no_late_valid", 64'(seen), 64'd0);
        do_op("mul_after_kill", 32'd3, 32'd4, 3'b000, c_F7_M, 32'd12, 1'b0, 1'b0, 2, 1'b1);

        // kill beats accept while idle
        @(negedge clk);
        kill     = 1'b1;
        in_valid = 1'b1;
        op1      = 32'd1;
        op2      = 32'd0;
        funct3   = 3'b101;
        funct7   = c_F7_M;
        @(posedge clk);
        @(negedge clk);
        kill     = 1'b0;
        in_valid = 1'b0;
        #1;
        check("kill_vs_accept_valid", 64'(out_valid), 64'd0);
        check("kill_vs_accept_ready", 64'(in_ready),  64'd1);

        // rst mid-divide clears everything
        start_op(32'd12345, 32'd11, 3'b100, c_F7_M);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_ready",  64'(in_ready),  64'd1);
        check("rst_mid_valid",  64'(out_valid), 64'd0);
        check("rst_mid_result", 64'(result),    64'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            seen = seen | out_valid;
        end
        check("rst_mid_no_valid", 64'(seen), 64'd0);
        do_op("divu_after_rst", 32'd100, 32'd7, 3'b101, c_F7_M, 32'd14, 1'b0, 1'b0, 33, 1'b1);

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/riscv_muldiv_unit.md
Name: riscv_muldiv_unit

Overview:
- Multi-cycle RISC-V M-extension execute unit.
- Sits beside the single-cycle integer ALU in the execute stage; instructions with opcode OP and funct7 0000001 are steered here.
- Multiplies take 2 cycles; divide and remainder use an iterative restoring divider that retires one quotient bit per cycle.
- Operands and results pass through a valid/ready handshake, so the pipeline stalls on busy.

Parameters:
- WIDTH, 32, operand and result width in bits; must be ≥ 4 and even.
- CNT_W, $clog2(WIDTH)+1, divider iteration counter width; derived, do not override.

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- kill  input  1  synchronous abort of an in-flight or completed operation (pipeline flush)
- in_valid  input  1  request valid
- in_ready  output  1  unit idle and able to accept a request
- op1  input  WIDTH  rs1 value
- op2  input  WIDTH  rs2 value
- funct3  input  3  M-op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- funct7  input  7  must be 0000001; any other value is illegal
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts the result
- result  output  WIDTH  operation result
- div_zero  output  1  the result came from a divide by zero (qualified by out_valid)
- illegal  output  1  funct7 was not 0000001; result is 0 (qualified by out_valid)

Behaviour:
- Reset is one clock, synchronous, active-high. Reset values:
  - state = IDLE, in_ready = 1, out_valid = 0
  - result = 0, div_zero = 0, illegal = 0
  - all internal registers cleared
- Reset asserted mid-operation discards the operation with no output.
- FSM states are IDLE, MUL, DIV, DONE.
- in_ready = (state == IDLE) and !kill. A request is accepted on any edge where in_valid && in_ready; op1, op2, funct3 and funct7 are latched on that edge.
- Transitions on the accept edge:
  - funct7 ≠ 0000001 → DONE; result 0, illegal = 1.
  - funct3[2] = 0 → MUL.
  - Divide with op2 = 0 → DONE, div_zero = 1:
    - DIV and DIVU give all ones.
    - REM and REMU give op1.
  - DIV or REM with op1 = 100…0 and op2 = all ones (signed overflow) → DONE:
    - DIV gives 100…0.
    - REM gives 0.
  - Any other divide → DIV with counter = WIDTH.
- MUL state: forms the 2·WIDTH product, then goes to DONE on the next edge.
  - Operands are sign-extended per op: MULH signed×signed, MULHSU signed×unsigned, MULHU and MUL unsigned.
  - MUL returns the low WIDTH bits; the MULH variants return the high WIDTH bits.
  - Latency from accept edge to out_valid high is 2 edges.
- DIV state performs a restoring division on magnitudes:
  - Signed ops use |op1| and |op2|; the unsigned ops use the raw values.
  - Each edge shifts in one dividend bit, trial-subtracts, sets one quotient bit and decrements the counter.
  - When the counter reaches 0 → DONE, applying the sign fix:
    - Quotient is negated if the operand signs differ (signed ops only).
    - Remainder takes the sign of op1.
  - Latency from accept edge to out_valid is WIDTH+1 edges (33 for WIDTH=32). Special cases take 1 edge.
- DONE state: out_valid = 1 and result/flags are stable.
  - Stays in DONE until out_valid && out_ready, then returns to IDLE. The unit cannot accept in the same cycle, since in_ready is 0.
  - out_valid drops and the flags clear on the handoff edge.
- kill from any state → IDLE on the next edge. Any pending result is dropped and no out_valid pulse occurs. kill takes precedence over accept and over handoff. rst takes precedence over kill.
- Inputs change while busy: ignored; the latched copies are used.
- result is registered; no combinational path from inputs to outputs except in_ready from kill.

Test Plan:
- Reset then MUL: op1=7, op2=0xFFFFFFFA, funct3=000 → out_valid 2 edges after accept, result 0xFFFFFFD6. in_ready=0 while busy.
- MULH / MULHSU / MULHU with op1=op2=0x80000000 → 0x40000000, 0xC0000000 and 0x40000000 respectively.
- DIV op1=-7 (0xFFFFFFF9), op2=2 → result 0xFFFFFFFD after exactly 33 edges. REM with the same operands → 0xFFFFFFFF. DIVU 100/7 → 14; REMU → 2.
- Corner cases:
  - DIVU 5/0 → 0xFFFFFFFF, div_zero=1, 1-edge latency.
  - REM 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - funct7=0x20 → result 0, illegal=1.
- Backpressure: out_ready=0 for 10 cycles in DONE → result held, out_valid held, in_ready stays 0. Raising out_ready for one cycle returns the unit to IDLE.
- kill asserted at divide iteration 10 → IDLE next edge with no out_valid. A following MUL 3×4 returns 12. Also check rst asserted mid-divide clears everything and in_ready=1 next cycle.
